// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64 instruction fetch: PC, one-outstanding imem request, instruction FIFO, redirect flush.
// Optional bubble counter behind FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] bubble_cnt,
`endif
  input  logic        inst_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [63:0]   RESET_PC_A = {RESET_PC[63:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   inst_mem_q [FIFO_DEPTH];
  logic [63:0]   pc_mem_q   [FIFO_DEPTH];
  logic          push, pop;
  logic          unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rptr_q];
  assign inst_pc    = pc_mem_q[rptr_q];
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;

  // Redirect suppresses both FIFO ports; the stale response is never buffered.
  assign pop  = inst_valid & inst_ready & ~redirect;
  assign push = (state_q == REQ) & imem_ack & ~redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rptr_d     = rptr_q + AW'(pop);
    wptr_d     = wptr_q + AW'(push);
    if (redirect) begin
      count_d    = '0;
      rptr_d     = wptr_q;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      // An unanswered request cannot be withdrawn, so wait out its ack in DROP.
      state_d    = ((state_q != IDLE) && !imem_ack) ? DROP : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if ((count_q - CW'(pop)) < DEPTH_C) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            if ((count_q + CW'(1) - CW'(pop)) < DEPTH_C) begin
              state_d = REQ;
              addr_d  = fetch_pc_q + 64'd4;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC_A;
      addr_q     <= RESET_PC_A;
      req_q      <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      if (push) begin
        inst_mem_q[wptr_q] <= imem_rdata;
        pc_mem_q[wptr_q]   <= fetch_pc_q;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_q;

  assign bubble_cnt = bubble_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= '0;
    end else if (inst_ready && !inst_valid && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit plus hand sequences for reset and idle redirect.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h1000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
`ifdef FETCH_PERF_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .inst_ready(inst_ready)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic        chk_data;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic redir, input logic [63:0] rpc, input logic e_req,
                              input logic [63:0] e_addr, input logic e_valid, input logic chk_data,
                              input logic [31:0] e_inst, input logic [63:0] e_pc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.chk_data = chk_data;
    v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic [31:0] exp_bub;
    exp_bub = '0;

    // ack,rdata,ready,redir,rpc | req,addr,valid,chk,inst,pc
    vecs[0]  = mk(0, 32'h0,        1, 0, 64'h0,    0, 64'h1000, 0, 1, 32'h0,        64'h0);
    vecs[1]  = mk(1, 32'h11111111, 1, 0, 64'h0,    1, 64'h1000, 0, 0, 32'h0,        64'h0);
    vecs[2]  = mk(1, 32'h22222222, 1, 0, 64'h0,    1, 64'h1004, 1, 1, 32'h11111111, 64'h1000);
    vecs[3]  = mk(1, 32'h33333333, 0, 0, 64'h0,    1, 64'h1008, 1, 1, 32'h22222222, 64'h1004);
    vecs[4]  = mk(1, 32'h0BADBAD0, 0, 0, 64'h0,    0, 64'h1008, 1, 1, 32'h22222222, 64'h1004);
    vecs[5]  = mk(0, 32'h0,        1, 0, 64'h0,    0, 64'h1008, 1, 1, 32'h22222222, 64'h1004);
    vecs[6]  = mk(0, 32'h0,        0, 0, 64'h0,    1, 64'h100C, 1, 1, 32'h33333333, 64'h1008);
    vecs[7]  = mk(0, 32'h0,        0, 0, 64'h0,    1, 64'h100C, 1, 1, 32'h33333333, 64'h1008);
    vecs[8]  = mk(0, 32'h0,        0, 0, 64'h0,    1, 64'h100C, 1, 1, 32'h33333333, 64'h1008);
    vecs[9]  = mk(1, 32'h44444444, 0, 0, 64'h0,    1, 64'h100C, 1, 1, 32'h33333333, 64'h1008);
    vecs[10] = mk(0, 32'h0,        1, 0, 64'h0,    0, 64'h100C, 1, 1, 32'h33333333, 64'h1008);
    vecs[11] = mk(0, 32'h0,        1, 1, 64'h2002, 1, 64'h1010, 1, 1, 32'h44444444, 64'h100C);
    vecs[12] = mk(0, 32'h0,        1, 0, 64'h0,    1, 64'h1010, 0, 0, 32'h0,        64'h0);
    vecs[13] = mk(1, 32'hDEADBEEF, 1, 0, 64'h0,    1, 64'h1010, 0, 0, 32'h0,        64'h0);
    vecs[14] = mk(1, 32'h55555555, 1, 0, 64'h0,    1, 64'h2000, 0, 0, 32'h0,        64'h0);
    vecs[15] = mk(1, 32'h66666666, 1, 1, 64'h3000, 1, 64'h2004, 1, 1, 32'h55555555, 64'h2000);
    vecs[16] = mk(0, 32'h0,        1, 0, 64'h0,    0, 64'h2004, 0, 0, 32'h0,        64'h0);
    vecs[17] = mk(1, 32'h77777777, 1, 0, 64'h0,    1, 64'h3000, 0, 0, 32'h0,        64'h0);
    vecs[18] = mk(0, 32'h0,        0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                                                   1, 64'h3004, 1, 1, 32'h77777777, 64'h3000);
    vecs[19] = mk(1, 32'h0BADF00D, 0, 0, 64'h0,    1, 64'h3004, 0, 0, 32'h0,        64'h0);
    vecs[20] = mk(1, 32'h88888888, 1, 0, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'h0, 64'h0);
    vecs[21] = mk(1, 32'h99999999, 1, 0, 64'h0,    1, 64'h0,    1, 1, 32'h88888888, 64'hFFFF_FFFF_FFFF_FFFC);
    vecs[22] = mk(0, 32'h0,        1, 0, 64'h0,    1, 64'h4,    1, 1, 32'h99999999, 64'h0);
    vecs[23] = mk(0, 32'h0,        0, 0, 64'h0,    1, 64'h4,    0, 0, 32'h0,        64'h0);

    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("v%0d imem_req", i), {63'h0, imem_req}, {63'h0, vecs[i].e_req});
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d inst_valid", i), {63'h0, inst_valid}, {63'h0, vecs[i].e_valid});
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d inst", i), {32'h0, inst}, {32'h0, vecs[i].e_inst});
        check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      check($sformatf("v%0d bubble_cnt", i), {32'h0, bubble_cnt}, {32'h0, exp_bub});
      if (vecs[i].ready && !vecs[i].e_valid) exp_bub = exp_bub + 32'd1;
`endif
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      inst_ready  = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
    end

    imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("pre-reset imem_req", {63'h0, imem_req}, 64'h1);
    #2 reset = 1'b0;
    #1;
    check("async reset imem_req", {63'h0, imem_req}, 64'h0);
    check("async reset imem_addr", imem_addr, 64'h1000);
    check("async reset inst_valid", {63'h0, inst_valid}, 64'h0);
    check("async reset inst", {32'h0, inst}, 64'h0);

    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!imem_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("first req latency", 64'(n), 64'd1);
    check("first req addr", imem_addr, 64'h1000);

    imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check("fill addr", imem_addr, 64'h1004);
    check("fill inst", {32'h0, inst}, 64'hAAAA_AAAA);
    check("fill inst_pc", inst_pc, 64'h1000);
    imem_rdata = 32'hBBBB_BBBB;
    @(negedge clk);
    check("full imem_req", {63'h0, imem_req}, 64'h0);
    check("full inst_valid", {63'h0, inst_valid}, 64'h1);
    imem_ack = 1'b0; inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h5000;
    @(negedge clk);
    check("idle redirect inst_valid", {63'h0, inst_valid}, 64'h0);
    check("idle redirect imem_req", {63'h0, imem_req}, 64'h0);
    redirect = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    check("post redirect imem_req", {63'h0, imem_req}, 64'h1);
    check("post redirect imem_addr", imem_addr, 64'h5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV64 core, directly upstream of the decode stage. Holds the program counter, issues one-at-a-time requests to instruction memory over a req/ack handshake, and buffers returned instructions in a small FIFO. Presents each instruction with its PC to decode over a valid/ready handshake. Handles branch/jump redirects with flush and discard of in-flight responses.

## Interface
Parameters:
- RESET_PC, 64'h0, PC fetched first after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥ 2

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  64  fetch address; bits[1:0] always 0
- imem_ack  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- redirect  in  1  taken branch/jump from later stage
- redirect_pc  in  64  new fetch target
- inst  out  32  instruction to decode (FIFO head)
- inst_pc  out  64  PC of inst
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  decode accepts inst this cycle
- bubble_cnt  out  32  only with FETCH_PERF_CNT_EN

## Operation
- FSM states: IDLE, REQ, DROP. Reset state IDLE.
- imem_req = 1 only in REQ and DROP. imem_addr = fetch_pc in REQ. In DROP it holds the address of the outstanding, stale request.
- pop = inst_valid & inst_ready. push = imem_ack in REQ with no redirect.
- IDLE → REQ when (count − pop) < FIFO_DEPTH.
- REQ with ack: push {imem_rdata, fetch_pc}, fetch_pc += 4. Stay in REQ if (count + 1 − pop) < FIFO_DEPTH, else go to IDLE.
- REQ without ack: hold imem_req and imem_addr stable. The request must not be withdrawn.
- DROP with ack: discard data, go to REQ with fetch_pc.
- DROP without ack: stay in DROP.
- Redirect (highest priority, any state):
  - Flush the FIFO (count ← 0). fetch_pc ← {redirect_pc[63:2], 2'b00}.
  - From REQ without ack, or from DROP without ack: go to DROP.
  - From REQ or DROP with ack in the same cycle: discard the data, go to IDLE.
  - From IDLE: go to IDLE.
  - Push and pop in the redirect cycle are suppressed.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- At most one outstanding imem request.
- PC arithmetic is modulo 2^64. A wrap from 64'hFFFF_FFFF_FFFF_FFFC goes to 0 silently.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst 0, inst_pc 0, inst_valid 0, count 0, bubble_cnt 0, FSM IDLE, fetch_pc RESET_PC.
- First imem_req=1 occurs in the first cycle after the first rising edge following reset release.
- Ack in cycle N: inst_valid=1 in cycle N+1, with inst and inst_pc from FIFO registers. Latency is 1 cycle.
- With imem_ack held 1 and inst_ready held 1, throughput is 1 instruction per cycle.
- Redirect in cycle N: inst_valid=0 in cycle N+1. The new target is requested (imem_addr = redirect_pc) from cycle N+2 at the earliest, or from the cycle after the stale ack if it was pending.
- Reset assertion mid-request drops imem_req immediately (asynchronous) and restores all reset values.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - bubble_cnt increments every cycle with inst_ready=1 and inst_valid=0.
  - It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- FETCH_PERF_CNT_EN undefined: the bubble_cnt port and its counter logic are absent.

## Test plan
- Reset release, RESET_PC=64'h1000, ack every cycle, ready=1 → imem_addr 1000, 1004, 1008… on consecutive cycles. inst_pc follows one cycle later. No gaps.
- Ready=0, ack=1 → exactly FIFO_DEPTH=2 pushes (PCs 1000, 1004). imem_req drops. imem_addr reads 1008 on re-request after the first pop.
- Ack withheld 5 cycles → imem_req stays 1 and imem_addr stays 1000 throughout. A single push occurs on ack.
- Redirect to 64'h2002 while a request to 1004 is outstanding → FSM enters DROP, FIFO flushes, inst_valid=0 next cycle. The stale 1004 ack is discarded. The next request is to 2000.
- Redirect in the same cycle as an ack and a pop → no push or pop. Count=0. The next request is to the redirect target.
- With FETCH_PERF_CNT_EN, ready=1 for 3 cycles after reset before the first valid → bubble_cnt=3 (plus any subsequent bubble cycles).
